lsu_align: RTL and testbench

- Load/store alignment unit in the MEM stage, directly upstream of the word-organised data memory.
- Takes a single load or store request from the pipeline and drives the memory's word address, byte-lane write mask, lane-shifted write data and write/read enables.
- Extracts, sign- or zero-extends and returns load data.
- Splits word-crossing (misaligned) accesses into two sequential word accesses.

---
 rtl/lsu_align_pkg.sv | 51 +++++
 rtl/lsu_align_if.sv | 31 +++
 rtl/lsu_load_extend.sv | 22 ++
 rtl/lsu_align.sv | 158 +++++++++++++++
 tb/tb_lsu_align.sv | 245 ++++++++++++++++++++++++
 5 files changed

// File: rtl/lsu_align_pkg.sv
// Shared types and helpers for the load/store alignment unit.
package lsu_pkg;

  typedef enum logic [2:0] {
    LSU_B  = 3'b000,
    LSU_H  = 3'b001,
    LSU_W  = 3'b010,
    LSU_BU = 3'b100,
    LSU_HU = 3'b101
  } lsu_funct3_e;

  typedef enum logic {
    IDLE   = 1'b0,
    SECOND = 1'b1
  } lsu_state_e;

  // Halfword at offset 3 or any word not on a word boundary spans two words.
  function automatic logic is_crossing(input logic [2:0] funct3, input logic [1:0] off);
    case (funct3)
      LSU_H, LSU_HU: return (off == 2'b11);
      LSU_W:         return (off != 2'b00);
      default:       return 1'b0;
    endcase
  endfunction

  function automatic logic [2:0] access_bytes(input logic [2:0] funct3);
    case (funct3)
      LSU_B, LSU_BU: return 3'd1;
      LSU_H, LSU_HU: return 3'd2;
      default:       return 3'd4;
    endcase
  endfunction

  // Byte enables of the access before lane rotation, bit k = access byte k.
  function automatic logic [3:0] byte_lanes(input logic [2:0] funct3);
    case (funct3)
      LSU_B, LSU_BU: return 4'b0001;
      LSU_H, LSU_HU: return 4'b0011;
      default:       return 4'b1111;
    endcase
  endfunction

  function automatic logic funct3_ok(input logic store, input logic [2:0] funct3);
    case (funct3)
      LSU_B, LSU_H, LSU_W: return 1'b1;
      LSU_BU, LSU_HU:      return ~store;
      default:             return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/lsu_align_if.sv
// Pipeline request/response and data-memory signals of the alignment unit.
// Handshake: a request transfers on a rising edge with req_valid && req_ready; resp_valid is a one-cycle pulse.
interface lsu_align_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_store;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_fault;
  logic [31:0] mem_addr;
  logic [31:0] mem_write_data;
  logic [3:0]  mem_data_mask;
  logic        mem_write_en;
  logic        mem_read_en;
  logic [31:0] mem_read_data;

  modport slave (
    input  req_valid, req_store, req_funct3, req_addr, req_wdata, mem_read_data,
    output req_ready, resp_valid, resp_rdata, resp_fault,
    output mem_addr, mem_write_data, mem_data_mask, mem_write_en, mem_read_en
  );

  modport master (
    output req_valid, req_store, req_funct3, req_addr, req_wdata, mem_read_data,
    input  req_ready, resp_valid, resp_rdata, resp_fault,
    input  mem_addr, mem_write_data, mem_data_mask, mem_write_en, mem_read_en
  );
endinterface

// File: rtl/lsu_load_extend.sv
// Sign/zero extension of the captured load bytes (byte k of the access in bits [8k+7:8k]).
module lsu_load_extend
  import lsu_pkg::*;
(
  input  logic [31:0] byte_buf,
  input  logic [2:0]  funct3,
  output logic [31:0] rdata
);

  always_comb begin
    rdata = '0;
    case (funct3)
      LSU_B:   rdata = {{24{byte_buf[7]}}, byte_buf[7:0]};
      LSU_H:   rdata = {{16{byte_buf[15]}}, byte_buf[15:0]};
      LSU_W:   rdata = byte_buf;
      LSU_BU:  rdata = {24'h0, byte_buf[7:0]};
      LSU_HU:  rdata = {16'h0, byte_buf[15:0]};
      default: rdata = '0;
    endcase
  end

endmodule

// File: rtl/lsu_align.sv
// MEM-stage load/store alignment unit in front of a word-organised data memory.
// Define LSU_MISALIGN_SPLIT_EN to split word-crossing accesses; otherwise they fault.
module lsu_align
  import lsu_pkg::*;
#(
  parameter int MEMORY_SIZE = 2048
) (
  input  logic       clk,
  input  logic       rst,
  lsu_align_if.slave bus,
  output lsu_state_e dbg_state
);

  lsu_state_e  state_q, state_d;
  logic        req_fire, acc_fault, addr_fault, crossing;
  logic [1:0]  off;
  logic [4:0]  shift;
  logic [3:0]  lanes, lat_lanes;
  logic [32:0] last_byte;
  logic [31:0] byte_buf, ext_data;
  logic [2:0]  lat_funct3;
  logic        resp_valid_q, resp_fault_q, resp_load_q;

`ifdef LSU_MISALIGN_SPLIT_EN
  logic        lat_store;
  logic [31:0] lat_addr, lat_wdata;
  logic [1:0]  back;
  // Bytes already handled in the first word: 4 - offset (offset is never 0 here).
  assign back = 2'b00 - lat_addr[1:0];
`endif

  assign off       = bus.req_addr[1:0];
  assign shift     = {off, 3'b000};
  assign lanes     = byte_lanes(bus.req_funct3);
  assign lat_lanes = byte_lanes(lat_funct3);
  assign crossing  = is_crossing(bus.req_funct3, off);

  // The final byte is checked in 33 bits so a wrap past 2^32 also faults.
  assign last_byte  = {1'b0, bus.req_addr} + 33'(access_bytes(bus.req_funct3)) - 33'd1;
  assign addr_fault = last_byte[32] | (last_byte[31:0] >= 32'(MEMORY_SIZE));
`ifdef LSU_MISALIGN_SPLIT_EN
  assign acc_fault  = ~funct3_ok(bus.req_store, bus.req_funct3) | addr_fault;
`else
  assign acc_fault  = ~funct3_ok(bus.req_store, bus.req_funct3) | addr_fault | crossing;
`endif

  assign bus.req_ready = (state_q == IDLE);
  assign req_fire      = bus.req_valid & bus.req_ready & ~rst;
  assign dbg_state     = state_q;

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
`ifdef LSU_MISALIGN_SPLIT_EN
        if (req_fire && !acc_fault && crossing) state_d = SECOND;
`endif
      end
      SECOND:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.mem_addr       = '0;
    bus.mem_write_data = '0;
    bus.mem_data_mask  = '0;
    bus.mem_write_en   = 1'b0;
    bus.mem_read_en    = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_fire && !acc_fault) begin
          bus.mem_addr       = {bus.req_addr[31:2], 2'b00};
          bus.mem_write_en   = bus.req_store;
          bus.mem_read_en    = ~bus.req_store;
          bus.mem_data_mask  = bus.req_store ? 4'(lanes << off) : 4'b1111;
          bus.mem_write_data = bus.req_store ? (bus.req_wdata << shift) : '0;
        end
      end
      SECOND: begin
`ifdef LSU_MISALIGN_SPLIT_EN
        // A reset arriving here aborts the second half before it reaches memory.
        if (!rst) begin
          bus.mem_addr       = {lat_addr[31:2], 2'b00} + 32'd4;
          bus.mem_write_en   = lat_store;
          bus.mem_read_en    = ~lat_store;
          bus.mem_data_mask  = lat_store ? (lat_lanes >> back) : 4'b1111;
          bus.mem_write_data = lat_store ? (lat_wdata >> {back, 3'b000}) : '0;
        end
`endif
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      resp_valid_q <= 1'b0;
      resp_fault_q <= 1'b0;
      resp_load_q  <= 1'b0;
      byte_buf     <= '0;
      lat_funct3   <= 3'b000;
`ifdef LSU_MISALIGN_SPLIT_EN
      lat_store    <= 1'b0;
      lat_addr     <= '0;
      lat_wdata    <= '0;
`endif
    end else begin
      resp_valid_q <= 1'b0;
      resp_fault_q <= 1'b0;
      if (req_fire) begin
        lat_funct3 <= bus.req_funct3;
`ifdef LSU_MISALIGN_SPLIT_EN
        lat_store  <= bus.req_store;
        lat_addr   <= bus.req_addr;
        lat_wdata  <= bus.req_wdata;
`endif
        if (acc_fault) begin
          resp_valid_q <= 1'b1;
          resp_fault_q <= 1'b1;
          resp_load_q  <= 1'b0;
          byte_buf     <= '0;
        end else begin
          // Access byte k sits in lane off+k; shifting right puts it at byte k of the buffer.
          byte_buf    <= bus.req_store ? '0 : (bus.mem_read_data >> shift);
          resp_load_q <= ~bus.req_store;
`ifdef LSU_MISALIGN_SPLIT_EN
          resp_valid_q <= ~crossing;
`else
          resp_valid_q <= 1'b1;
`endif
        end
      end
`ifdef LSU_MISALIGN_SPLIT_EN
      if (state_q == SECOND) begin
        resp_valid_q <= 1'b1;
        if (!lat_store) byte_buf <= byte_buf | (bus.mem_read_data << {back, 3'b000});
      end
`endif
    end
  end

  lsu_load_extend u_extend (
    .byte_buf (byte_buf),
    .funct3   (lat_funct3),
    .rdata    (ext_data)
  );

  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_fault = resp_fault_q;
  assign bus.resp_rdata = (resp_valid_q && resp_load_q) ? ext_data : '0;

endmodule

// File: tb/tb_lsu_align.sv
// Directed bench for lsu_align: vector table of single requests plus hand-written multi-cycle sequences.
module tb_lsu_align;
  import lsu_pkg::*;

`ifdef LSU_MISALIGN_SPLIT_EN
  localparam bit SPLIT = 1'b1;
`else
  localparam bit SPLIT = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       preload_req = 1'b1;
  lsu_state_e dbg_state;
  int         n_checks = 0;
  int         n_pass = 0;

  lsu_align_if bus ();

  lsu_align #(.MEMORY_SIZE(2048)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  always #5 clk = ~clk;

  // Data memory model: combinational read, byte-masked write at the clock edge.
  logic [31:0] mem [0:511];
  assign bus.mem_read_data = mem[bus.mem_addr[10:2]];

  always @(posedge clk) begin
    if (preload_req) begin
      for (int w = 0; w < 512; w++) mem[w] <= 32'h0;
      mem[4] <= 32'h8899AABB;
      mem[5] <= 32'h11223344;
    end else if (bus.mem_write_en) begin
      for (int k = 0; k < 4; k++)
        if (bus.mem_data_mask[k]) mem[bus.mem_addr[10:2]][8*k +: 8] <= bus.mem_write_data[8*k +: 8];
    end
  end

  typedef struct {
    logic        st;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          lat;
    logic [31:0] rdata;
    logic        fault;
    string       name;
  } vec_t;

  vec_t vecs[16];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, got, exp);
  endtask

  task automatic preload();
    preload_req = 1'b1;
    @(posedge clk);
    #1 preload_req = 1'b0;
  endtask

  task automatic set_req(input logic st, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
    bus.req_valid  = 1'b1;
    bus.req_store  = st;
    bus.req_funct3 = f3;
    bus.req_addr   = a;
    bus.req_wdata  = wd;
  endtask

  // Called just after a rising edge; returns 0 latency if no response within the budget.
  task automatic run_req(input logic st, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd,
                         output int lat, output logic [31:0] rd, output logic flt,
                         output logic we1, output logic [3:0] m1, output logic rdy1);
    set_req(st, f3, a, wd);
    @(negedge clk);
    we1 = bus.mem_write_en;
    m1  = bus.mem_data_mask;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    lat = 0; rd = 32'h0; flt = 1'b0; rdy1 = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      if (i == 1) rdy1 = bus.req_ready;
      if (bus.resp_valid) begin
        lat = i;
        rd  = bus.resp_rdata;
        flt = bus.resp_fault;
        break;
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    int          lat;
    int          hits;
    logic [31:0] rd;
    logic        flt, we1, rdy1;
    logic [3:0]  m1;

    vecs[0]  = '{1'b0, 3'b000, 32'h13, 32'h0, 1, 32'hFFFFFF88, 1'b0, "lb_13"};
    vecs[1]  = '{1'b0, 3'b100, 32'h10, 32'h0, 1, 32'h000000BB, 1'b0, "lbu_10"};
    vecs[2]  = '{1'b0, 3'b001, 32'h12, 32'h0, 1, 32'hFFFF8899, 1'b0, "lh_12"};
    vecs[3]  = '{1'b0, 3'b101, 32'h10, 32'h0, 1, 32'h0000AABB, 1'b0, "lhu_10"};
    vecs[4]  = '{1'b0, 3'b010, 32'h14, 32'h0, 1, 32'h11223344, 1'b0, "lw_14"};
    vecs[5]  = '{1'b0, 3'b101, 32'h13, 32'h0, SPLIT ? 2 : 1, SPLIT ? 32'h00004488 : 32'h0, !SPLIT, "lhu_13_cross"};
    vecs[6]  = '{1'b0, 3'b010, 32'h11, 32'h0, SPLIT ? 2 : 1, SPLIT ? 32'h448899AA : 32'h0, !SPLIT, "lw_11_cross"};
    vecs[7]  = '{1'b0, 3'b001, 32'h11, 32'h0, 1, 32'hFFFF99AA, 1'b0, "lh_11"};
    vecs[8]  = '{1'b0, 3'b011, 32'h10, 32'h0, 1, 32'h0, 1'b1, "ld_f3_011"};
    vecs[9]  = '{1'b0, 3'b010, 32'h7FE, 32'h0, 1, 32'h0, 1'b1, "lw_7fe"};
    vecs[10] = '{1'b0, 3'b010, 32'h7FC, 32'h0, 1, 32'h0, 1'b0, "lw_7fc"};
    vecs[11] = '{1'b0, 3'b000, 32'h800, 32'h0, 1, 32'h0, 1'b1, "lb_800"};
    vecs[12] = '{1'b1, 3'b100, 32'h10, 32'hFF, 1, 32'h0, 1'b1, "st_f3_100"};
    vecs[13] = '{1'b0, 3'b010, 32'hFFFFFFFE, 32'h0, 1, 32'h0, 1'b1, "lw_wrap"};
    vecs[14] = '{1'b1, 3'b001, 32'h7FF, 32'h1234, 1, 32'h0, 1'b1, "sh_7ff"};
    vecs[15] = '{1'b0, 3'b110, 32'h10, 32'h0, 1, 32'h0, 1'b1, "ld_f3_110"};

    // Reset state; a request held during reset must not be accepted.
    set_req(1'b0, 3'b010, 32'h10, 32'h0);
    @(posedge clk);
    @(negedge clk);
    chk("rst.resp_valid", 32'(bus.resp_valid), 32'h0);
    chk("rst.resp_rdata", bus.resp_rdata, 32'h0);
    chk("rst.resp_fault", 32'(bus.resp_fault), 32'h0);
    chk("rst.req_ready", 32'(bus.req_ready), 32'h1);
    chk("rst.mem_read_en", 32'(bus.mem_read_en), 32'h0);
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    rst = 1'b0;
    preload_req = 1'b0;
    @(negedge clk);
    chk("rst.not_accepted", 32'(bus.resp_valid), 32'h0);
    @(posedge clk);
    #1;

    for (int i = 0; i < 16; i++) begin
      run_req(vecs[i].st, vecs[i].f3, vecs[i].addr, vecs[i].wdata, lat, rd, flt, we1, m1, rdy1);
      chk({vecs[i].name, ".latency"}, 32'(lat), 32'(vecs[i].lat));
      chk({vecs[i].name, ".rdata"}, rd, vecs[i].rdata);
      chk({vecs[i].name, ".fault"}, 32'(flt), 32'(vecs[i].fault));
      chk({vecs[i].name, ".write_en"}, 32'(we1), 32'(vecs[i].st && !vecs[i].fault));
      chk({vecs[i].name, ".ready_c1"}, 32'(rdy1), 32'(vecs[i].lat == 1));
      if (!vecs[i].fault && !vecs[i].st) chk({vecs[i].name, ".mask"}, 32'(m1), 32'hF);
    end
    chk("st_fault.mem_unchanged", mem[4], 32'h8899AABB);

    // SB then back-to-back LW.
    preload();
    set_req(1'b1, 3'b000, 32'h11, 32'h000000A5);
    @(negedge clk);
    chk("sb.mask", 32'(bus.mem_data_mask), 32'h2);
    chk("sb.lane1", {24'h0, bus.mem_write_data[15:8]}, 32'hA5);
    chk("sb.we", 32'(bus.mem_write_en), 32'h1);
    chk("sb.addr", bus.mem_addr, 32'h10);
    @(posedge clk);
    #1 set_req(1'b0, 3'b010, 32'h10, 32'h0);
    @(negedge clk);
    chk("sb.resp_valid", 32'(bus.resp_valid), 32'h1);
    chk("sb.resp_fault", 32'(bus.resp_fault), 32'h0);
    chk("sb.resp_rdata", bus.resp_rdata, 32'h0);
    chk("lw_b2b.read_en", 32'(bus.mem_read_en), 32'h1);
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    @(negedge clk);
    chk("lw_b2b.resp_valid", 32'(bus.resp_valid), 32'h1);
    chk("lw_b2b.rdata", bus.resp_rdata, 32'h8899A5BB);
    chk("sb.mem10", mem[4], 32'h8899A5BB);
    @(posedge clk);
    #1;

    // SW crossing at 0x12.
    preload();
    set_req(1'b1, 3'b010, 32'h12, 32'hDEADBEEF);
    @(negedge clk);
    chk("sw.we1", 32'(bus.mem_write_en), 32'(SPLIT));
`ifdef LSU_MISALIGN_SPLIT_EN
    chk("sw.addr1", bus.mem_addr, 32'h10);
    chk("sw.mask1", 32'(bus.mem_data_mask), 32'hC);
    chk("sw.data1_hi", {16'h0, bus.mem_write_data[31:16]}, 32'hBEEF);
`endif
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    @(negedge clk);
`ifdef LSU_MISALIGN_SPLIT_EN
    chk("sw.addr2", bus.mem_addr, 32'h14);
    chk("sw.mask2", 32'(bus.mem_data_mask), 32'h3);
    chk("sw.data2_lo", {16'h0, bus.mem_write_data[15:0]}, 32'hDEAD);
    chk("sw.we2", 32'(bus.mem_write_en), 32'h1);
    chk("sw.ready2", 32'(bus.req_ready), 32'h0);
    chk("sw.state2", 32'(dbg_state), 32'(SECOND));
    chk("sw.no_early_resp", 32'(bus.resp_valid), 32'h0);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("sw.resp_valid", 32'(bus.resp_valid), 32'h1);
    chk("sw.resp_fault", 32'(bus.resp_fault), 32'h0);
    chk("sw.mem10", mem[4], 32'hBEEFAABB);
    chk("sw.mem14", mem[5], 32'h1122DEAD);
`else
    chk("sw.resp_valid", 32'(bus.resp_valid), 32'h1);
    chk("sw.resp_fault", 32'(bus.resp_fault), 32'h1);
    chk("sw.resp_rdata", bus.resp_rdata, 32'h0);
    chk("sw.mem10", mem[4], 32'h8899AABB);
    chk("sw.mem14", mem[5], 32'h11223344);
`endif
    @(posedge clk);
    #1;

`ifdef LSU_MISALIGN_SPLIT_EN
    // Reset during SECOND of the same SW aborts the second half and the response.
    preload();
    set_req(1'b1, 3'b010, 32'h12, 32'hDEADBEEF);
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    chk("abort.we2", 32'(bus.mem_write_en), 32'h0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("abort.ready", 32'(bus.req_ready), 32'h1);
    chk("abort.state", 32'(dbg_state), 32'(IDLE));
    hits = 32'(bus.resp_valid);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      hits += 32'(bus.resp_valid);
    end
    chk("abort.no_resp", 32'(hits), 32'h0);
    chk("abort.mem10", mem[4], 32'hBEEFAABB);
    chk("abort.mem14", mem[5], 32'h11223344);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
